css_rst_seq_ctrl: RTL and testbench
===================================

# css_rst_seq_ctrl

Synthesizable, parametrised power-good/reset sequencer for the Caliptra subsystem. It drives `cptra_pwrgood` plus `NUM_DOMAINS` ordered active-low reset outputs, and accepts warm and hard assert/deassert commands over a valid/ready handshake. Reset entry is preceded by an MCU halt request/ack handshake with a bounded timeout. It sits between the SoC reset controller (or test services) and the Caliptra/MCI reset inputs, generalising the fixed-delay single-domain sequencing to N domains with programmable per-domain release delays.

## Interface
Parameters:
- `NUM_DOMAINS`, default 2: number of reset domains; each is released in ascending index order. Legal range 1..8.
- `CNT_W`, default 16: width of each delay field.
- `HALT_TO_CYC`, default 1024: maximum number of cycles to wait for halt ack. Must be ≥1.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `core_clk`, in, 1: clock.
  - `core_rst`, in, 1: synchronous, active-high reset.
- Command handshake:
  - `cmd_valid_i`, in, 1: command request.
  - `cmd_i`, in, 2: command code. 00 = warm assert, 01 = warm deassert, 10 = hard assert, 11 = hard deassert.
  - `cmd_ready_o`, out, 1: block can accept a command.
- Delay configuration:
  - `pg_dly_i`, in, CNT_W: delay from pwrgood rise to domain 0 release.
  - `dom_dly_i`, in, NUM_DOMAINS*CNT_W: per-domain release delay. Field i occupies bits [i*CNT_W +: CNT_W].
- Reset outputs:
  - `cptra_pwrgood_o`, out, 1: power good.
  - `rst_b_o`, out, NUM_DOMAINS: active-low domain resets.
- MCU halt handshake:
  - `halt_req_o`, out, 1: MCU halt request.
  - `halt_ack_i`, in, 1: MCU halt acknowledge (level).
- Completion status:
  - `done_o`, out, 1: single-cycle completion pulse.
  - `done_err_o`, out, 1: qualifies `done_o`; the command was illegal in the current state.
  - `done_timeout_o`, out, 1: qualifies `done_o`; the halt phase timed out.
- `busy_o`, out, 1: sequence in progress; equal to !`cmd_ready_o`.

## Operation
- States:
  - OFF: pwrgood=0, all rst_b=0.
  - PG_WAIT
  - REL(i): releasing domain i.
  - ON: pwrgood=1, all rst_b=1.
  - HALT
  - WARM: pwrgood=1, all rst_b=0.
- Idle states are OFF, ON and WARM. `cmd_ready_o` is 1 only in these states.
- A command is accepted on a cycle where `cmd_valid_i` and `cmd_ready_o` are both 1. Delay inputs are sampled when they are loaded into the counter, so software must hold them stable while busy.
- Legal transitions:
  - OFF + hard deassert → PG_WAIT. `cptra_pwrgood_o` rises the next cycle and the counter loads `pg_dly_i`.
  - PG_WAIT, when count expires → REL(0) with the counter loaded from `dom_dly_i[0]`.
  - REL(i), when count expires → rst_b_o[i]=1. The block then goes to REL(i+1), or to ON with done when i = NUM_DOMAINS-1.
  - WARM + warm deassert → REL(0) directly (pwrgood already high).
  - ON + warm assert or hard assert → HALT. `halt_req_o`=1 and the timeout counter loads HALT_TO_CYC.
  - HALT, when ack is seen or timeout expires:
    - All rst_b_o drop to 0 in the same cycle and `halt_req_o` drops.
    - Hard assert also drops pwrgood and goes to OFF; warm assert goes to WARM.
    - done pulses, with `done_timeout_o`=1 if the exit was by timeout.
  - WARM + hard assert → OFF immediately (no halt, since the MCU is already in reset). done pulses.
- Illegal commands (every other state/command pair, e.g. hard deassert in ON, warm deassert in OFF):
  - Accepted.
  - No output change.
  - `done_o`=1 and `done_err_o`=1 the next cycle.
- Counter: down-counter of CNT_W bits. A loaded value D expires after D+1 cycles, so D=0 gives a 1-cycle step. There is no wrap; expiry is at zero.

## Timing
- Reset values:
  - `cptra_pwrgood_o`=0, `rst_b_o`=0, `halt_req_o`=0.
  - `done_o`=0, `done_err_o`=0, `done_timeout_o`=0.
  - `cmd_ready_o`=1, `busy_o`=0.
  - State = OFF.
- All outputs are registered.
- Hard deassert accepted at cycle T:
  - pwrgood rises at T+1.
  - rst_b_o[0] rises at T+1+pg_dly+1+dom_dly[0]+1.
  - Each rst_b_o[i] rises dom_dly[i]+1 cycles after rst_b_o[i-1].
  - `done_o` fires in the same cycle the last domain rises.
- Halt exit:
  - If `halt_ack_i` is sampled 1 at cycle A, resets assert at A+1.
  - If ack arrives in the same cycle the timeout reaches zero, ack wins and `done_timeout_o`=0.
  - The timeout path asserts reset HALT_TO_CYC+1 cycles after HALT entry.
- `done_o` is exactly one cycle wide. The status flags are valid only while `done_o`=1 and are 0 otherwise.
- `core_rst` asserted in any state, mid-sequence included: on the next edge all outputs return to their reset values. There is no halt handshake and no done pulse.
- `cmd_valid_i` held while busy is ignored. The command is accepted on the first idle cycle.

## Test plan
- Reset, then hard deassert with pg_dly=4, dom_dly={2,3}, NUM_DOMAINS=2:
  - pwrgood at T+1, rst_b[0] at T+9, rst_b[1] at T+13.
  - One `done_o` pulse with err=0.
- From ON, warm assert with `halt_ack_i` raised 5 cycles after `halt_req_o`:
  - All rst_b low one cycle after ack; pwrgood stays 1; `halt_req_o` drops.
  - done=1, timeout=0.
- From ON, hard assert with HALT_TO_CYC=8 and ack never raised:
  - Resets and pwrgood drop 9 cycles after HALT entry.
  - done=1, done_timeout_o=1.
- Hard deassert issued in ON, and warm deassert issued in OFF:
  - Each gives done=1, err=1.
  - Outputs unchanged.
- Assert `core_rst` while rst_b[0]=1 and rst_b[1]=0:
  - Next edge: pwrgood=0, rst_b=0, `cmd_ready_o`=1, no done.
- Ack and timeout expiry coincide in the same cycle:
  - timeout=0.
  - Delay of 0 on all fields gives 1-cycle steps.

Source files
------------

// File: rtl/css_rst_seq_ctrl.sv
// Power-good / reset sequencer for the Caliptra subsystem.
// Raises cptra_pwrgood, then releases NUM_DOMAINS active-low resets in ascending
// order with programmable delays. Reset entry from ON is gated by an MCU halt
// handshake bounded by HALT_TO_CYC cycles. Every output is driven from a flop.

module css_rst_seq_ctrl #(
    parameter int unsigned NUM_DOMAINS = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned HALT_TO_CYC = 1024
) (
    input  logic                         core_clk,
    input  logic                         core_rst,

    input  logic                         cmd_valid_i,
    input  logic [1:0]                   cmd_i,
    output logic                         cmd_ready_o,

    input  logic [CNT_W-1:0]             pg_dly_i,
    input  logic [NUM_DOMAINS*CNT_W-1:0] dom_dly_i,

    output logic                         cptra_pwrgood_o,
    output logic [NUM_DOMAINS-1:0]       rst_b_o,

    output logic                         halt_req_o,
    input  logic                         halt_ack_i,

    output logic                         done_o,
    output logic                         done_err_o,
    output logic                         done_timeout_o,
    output logic                         busy_o
);

    // Domain index is padded to a power-of-two table so any index value is in range.
    localparam int unsigned IdxW     = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int unsigned NumSlots = 1 << IdxW;
    localparam int unsigned ToW      = $clog2(HALT_TO_CYC + 1);

    localparam logic [IdxW-1:0] LastIdx    = IdxW'(NUM_DOMAINS - 1);
    localparam logic [ToW-1:0]  HaltToInit = ToW'(HALT_TO_CYC);

    typedef enum logic [1:0] {
        CmdWarmAssert   = 2'b00,
        CmdWarmDeassert = 2'b01,
        CmdHardAssert   = 2'b10,
        CmdHardDeassert = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        StOff,
        StPgWait,
        StRel,
        StOn,
        StHalt,
        StWarm
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [ToW-1:0]          halt_cnt_q;
    logic [IdxW-1:0]         dom_idx_q;
    logic                    hard_q;
    logic                    pwrgood_q;
    logic [NUM_DOMAINS-1:0]  rst_b_q;
    logic                    halt_req_q;
    logic                    done_q;
    logic                    done_err_q;
    logic                    done_to_q;
    logic                    ready_q;
    logic                    busy_q;

    logic [CNT_W-1:0]        dom_dly_tab [NumSlots];
    logic                    cmd_accept;
    cmd_e                    cmd;
    logic [IdxW-1:0]         next_idx;
    logic [NUM_DOMAINS-1:0]  rel_mask;

    // Unpack the flat delay bus; unused padding slots read as zero.
    for (genvar g = 0; g < NumSlots; g++) begin : gen_dly_tab
        if (g < NUM_DOMAINS) begin : gen_used
            assign dom_dly_tab[g] = dom_dly_i[g*CNT_W +: CNT_W];
        end else begin : gen_pad
            assign dom_dly_tab[g] = '0;
        end
    end

    assign cmd_accept = cmd_valid_i & ready_q;
    assign cmd        = cmd_e'(cmd_i);
    assign next_idx   = dom_idx_q + 1'b1;
    assign rel_mask   = NUM_DOMAINS'(1) << dom_idx_q;

    // Sequencer FSM: state, counters and all registered outputs.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q    <= StOff;
            cnt_q      <= '0;
            halt_cnt_q <= '0;
            dom_idx_q  <= '0;
            hard_q     <= 1'b0;
            pwrgood_q  <= 1'b0;
            rst_b_q    <= '0;
            halt_req_q <= 1'b0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
            done_to_q  <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses.
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
            done_to_q  <= 1'b0;

            case (state_q)
                StOff: begin
                    if (cmd_accept) begin
                        if (cmd == CmdHardDeassert) begin
                            state_q   <= StPgWait;
                            pwrgood_q <= 1'b1;
                            cnt_q     <= pg_dly_i;
                            ready_q   <= 1'b0;
                            busy_q    <= 1'b1;
                        end else begin
                            done_q     <= 1'b1;
                            done_err_q <= 1'b1;
                        end
                    end
                end

                StPgWait: begin
                    if (cnt_q == '0) begin
                        state_q   <= StRel;
                        dom_idx_q <= '0;
                        cnt_q     <= dom_dly_tab[0];
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                StRel: begin
                    if (cnt_q == '0) begin
                        rst_b_q <= rst_b_q | rel_mask;
                        if (dom_idx_q == LastIdx) begin
                            state_q <= StOn;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            dom_idx_q <= next_idx;
                            cnt_q     <= dom_dly_tab[next_idx];
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                StOn: begin
                    if (cmd_accept) begin
                        if (cmd == CmdWarmAssert || cmd == CmdHardAssert) begin
                            state_q    <= StHalt;
                            hard_q     <= (cmd == CmdHardAssert);
                            halt_req_q <= 1'b1;
                            halt_cnt_q <= HaltToInit;
                            ready_q    <= 1'b0;
                            busy_q     <= 1'b1;
                        end else begin
                            done_q     <= 1'b1;
                            done_err_q <= 1'b1;
                        end
                    end
                end

                StHalt: begin
                    // Ack takes priority over a timeout expiring in the same cycle.
                    if (halt_ack_i || halt_cnt_q == '0) begin
                        rst_b_q    <= '0;
                        halt_req_q <= 1'b0;
                        done_q     <= 1'b1;
                        done_to_q  <= ~halt_ack_i;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        if (hard_q) begin
                            pwrgood_q <= 1'b0;
                            state_q   <= StOff;
                        end else begin
                            state_q <= StWarm;
                        end
                    end else begin
                        halt_cnt_q <= halt_cnt_q - 1'b1;
                    end
                end

                StWarm: begin
                    if (cmd_accept) begin
                        if (cmd == CmdWarmDeassert) begin
                            // Power is already good; go straight to domain release.
                            state_q   <= StRel;
                            dom_idx_q <= '0;
                            cnt_q     <= dom_dly_tab[0];
                            ready_q   <= 1'b0;
                            busy_q    <= 1'b1;
                        end else if (cmd == CmdHardAssert) begin
                            // MCU is already held in reset, so no halt handshake.
                            state_q   <= StOff;
                            pwrgood_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            done_q     <= 1'b1;
                            done_err_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q    <= StOff;
                    pwrgood_q  <= 1'b0;
                    rst_b_q    <= '0;
                    halt_req_q <= 1'b0;
                    ready_q    <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o     = ready_q;
    assign busy_o          = busy_q;
    assign cptra_pwrgood_o = pwrgood_q;
    assign rst_b_o         = rst_b_q;
    assign halt_req_o      = halt_req_q;
    assign done_o          = done_q;
    assign done_err_o      = done_err_q;
    assign done_timeout_o  = done_to_q;

endmodule

// File: tb/tb_css_rst_seq_ctrl.sv
// Bench for css_rst_seq_ctrl: completions are predicted into a scoreboard queue
// when each command is driven and matched (cycle and flags) when done_o fires.

module tb_css_rst_seq_ctrl;

    localparam int unsigned NumDom = 2;
    localparam int unsigned CntW   = 16;
    localparam int unsigned HaltTo = 8;

    localparam logic [1:0] CmdWA = 2'b00;
    localparam logic [1:0] CmdWD = 2'b01;
    localparam logic [1:0] CmdHA = 2'b10;
    localparam logic [1:0] CmdHD = 2'b11;

    logic                   core_clk = 1'b0;
    logic                   core_rst;
    logic                   cmd_valid_i;
    logic [1:0]             cmd_i;
    logic                   cmd_ready_o;
    logic [CntW-1:0]        pg_dly_i;
    logic [NumDom*CntW-1:0] dom_dly_i;
    logic                   cptra_pwrgood_o;
    logic [NumDom-1:0]      rst_b_o;
    logic                   halt_req_o;
    logic                   halt_ack_i;
    logic                   done_o;
    logic                   done_err_o;
    logic                   done_timeout_o;
    logic                   busy_o;

    css_rst_seq_ctrl #(
        .NUM_DOMAINS (NumDom),
        .CNT_W       (CntW),
        .HALT_TO_CYC (HaltTo)
    ) dut (
        .core_clk        (core_clk),
        .core_rst        (core_rst),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_i           (cmd_i),
        .cmd_ready_o     (cmd_ready_o),
        .pg_dly_i        (pg_dly_i),
        .dom_dly_i       (dom_dly_i),
        .cptra_pwrgood_o (cptra_pwrgood_o),
        .rst_b_o         (rst_b_o),
        .halt_req_o      (halt_req_o),
        .halt_ack_i      (halt_ack_i),
        .done_o          (done_o),
        .done_err_o      (done_err_o),
        .done_timeout_o  (done_timeout_o),
        .busy_o          (busy_o)
    );

    always #5 core_clk = ~core_clk;

    int unsigned cyc = 0;
    always @(posedge core_clk) cyc <= cyc + 1;

    typedef struct {
        logic              err;
        logic              to;
        logic              pg;
        logic [NumDom-1:0] rstb;
        int unsigned       at;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge core_clk);
    endtask

    task automatic expect_done(input logic e, input logic to, input logic pg,
                               input logic [NumDom-1:0] rb, input int unsigned at);
        exp_t x;
        x.err  = e;
        x.to   = to;
        x.pg   = pg;
        x.rstb = rb;
        x.at   = at;
        sb_q.push_back(x);
    endtask

    // Drive one command for a single cycle; block must be idle when called.
    task automatic issue(input logic [1:0] c);
        check_eq("ready_before_cmd", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_i       = c;
        @(negedge core_clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic pg, input logic [NumDom-1:0] rb,
                             input logic hr);
        check_eq({tag, "_pg"}, cptra_pwrgood_o, pg);
        check_eq({tag, "_rstb"}, rst_b_o, rb);
        check_eq({tag, "_halt"}, halt_req_o, hr);
    endtask

    // Completion monitor: pop the oldest prediction on every done pulse.
    always @(negedge core_clk) begin
        if (done_o) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_done", done_o, 0);
            end else begin
                check_eq("done_cycle", cyc, sb_q[0].at);
                check_eq("done_err", done_err_o, sb_q[0].err);
                check_eq("done_timeout", done_timeout_o, sb_q[0].to);
                check_eq("done_pg", cptra_pwrgood_o, sb_q[0].pg);
                check_eq("done_rstb", rst_b_o, sb_q[0].rstb);
                sb_q.delete(0);
            end
        end else begin
            check_eq("flags_idle", {done_err_o, done_timeout_o}, 2'b00);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        int unsigned acc;
        logic        found;

        core_rst    = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_i       = 2'b00;
        pg_dly_i    = '0;
        dom_dly_i   = '0;
        halt_ack_i  = 1'b0;
        acc         = 0;
        found       = 1'b0;

        // Reset values
        tick(3);
        check_out("rst", 1'b0, 2'b00, 1'b0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_ready", cmd_ready_o, 1);
        check_eq("rst_busy", busy_o, 0);
        core_rst = 1'b0;
        tick(1);

        // Hard deassert: pg=4, dom0=2, dom1=3 -> rst_b[0] at T+9, rst_b[1] at T+13
        pg_dly_i  = 16'd4;
        dom_dly_i = {16'd3, 16'd2};
        t = cyc;
        expect_done(1'b0, 1'b0, 1'b1, 2'b11, t + 13);
        issue(CmdHD);
        for (int k = 1; k <= 13; k++) begin
            check_eq("hd_pg", cptra_pwrgood_o, 1);
            check_eq("hd_rstb", rst_b_o, {(k >= 13) ? 1'b1 : 1'b0, (k >= 9) ? 1'b1 : 1'b0});
            if (k < 13) begin
                check_eq("hd_busy", busy_o, 1);
                tick(1);
            end
        end
        check_eq("hd_ready_end", cmd_ready_o, 1);
        check_eq("hd_busy_end", busy_o, 0);
        tick(1);

        // Warm assert from ON, ack raised 5 cycles after halt_req
        t = cyc;
        expect_done(1'b0, 1'b0, 1'b1, 2'b00, t + 7);
        issue(CmdWA);
        for (int k = 1; k <= 5; k++) begin
            check_out("wa_halt", 1'b1, 2'b11, 1'b1);
            tick(1);
        end
        halt_ack_i = 1'b1;
        check_out("wa_ack", 1'b1, 2'b11, 1'b1);
        tick(1);
        check_out("wa_exit", 1'b1, 2'b00, 1'b0);
        halt_ack_i = 1'b0;
        tick(1);

        // Warm deassert from WARM with zero delays: one-cycle steps
        dom_dly_i = '0;
        t = cyc;
        expect_done(1'b0, 1'b0, 1'b1, 2'b11, t + 3);
        issue(CmdWD);
        check_out("wd_t1", 1'b1, 2'b00, 1'b0);
        tick(1);
        check_out("wd_t2", 1'b1, 2'b01, 1'b0);
        tick(1);
        check_out("wd_t3", 1'b1, 2'b11, 1'b0);
        tick(1);

        // Illegal: hard deassert in ON
        t = cyc;
        expect_done(1'b1, 1'b0, 1'b1, 2'b11, t + 1);
        issue(CmdHD);
        check_out("ill_on", 1'b1, 2'b11, 1'b0);
        tick(1);

        // Hard assert from ON, ack never raised: timeout exit 9 cycles after HALT entry
        t = cyc;
        expect_done(1'b0, 1'b1, 1'b0, 2'b00, t + 10);
        issue(CmdHA);
        for (int k = 1; k <= 9; k++) begin
            check_out("to_halt", 1'b1, 2'b11, 1'b1);
            tick(1);
        end
        check_out("to_exit", 1'b0, 2'b00, 1'b0);
        check_eq("to_ready", cmd_ready_o, 1);
        tick(1);

        // Illegal: warm deassert and hard assert in OFF
        t = cyc;
        expect_done(1'b1, 1'b0, 1'b0, 2'b00, t + 1);
        issue(CmdWD);
        check_out("ill_off_wd", 1'b0, 2'b00, 1'b0);
        tick(1);
        t = cyc;
        expect_done(1'b1, 1'b0, 1'b0, 2'b00, t + 1);
        issue(CmdHA);
        check_out("ill_off_ha", 1'b0, 2'b00, 1'b0);
        tick(1);

        // Hard deassert with all delays zero
        pg_dly_i  = '0;
        dom_dly_i = '0;
        t = cyc;
        expect_done(1'b0, 1'b0, 1'b1, 2'b11, t + 4);
        issue(CmdHD);
        check_out("hd0_t1", 1'b1, 2'b00, 1'b0);
        tick(1);
        check_out("hd0_t2", 1'b1, 2'b00, 1'b0);
        tick(1);
        check_out("hd0_t3", 1'b1, 2'b01, 1'b0);
        tick(1);
        check_out("hd0_t4", 1'b1, 2'b11, 1'b0);
        tick(1);

        // Warm assert with ack arriving as the timeout reaches zero: ack wins
        t = cyc;
        expect_done(1'b0, 1'b0, 1'b1, 2'b00, t + 10);
        issue(CmdWA);
        tick(8);
        halt_ack_i = 1'b1;
        check_out("co_ack", 1'b1, 2'b11, 1'b1);
        tick(1);
        check_out("co_exit", 1'b1, 2'b00, 1'b0);
        halt_ack_i = 1'b0;
        tick(1);

        // Hard assert from WARM: straight to OFF
        t = cyc;
        expect_done(1'b0, 1'b0, 1'b0, 2'b00, t + 1);
        issue(CmdHA);
        check_out("warm_ha", 1'b0, 2'b00, 1'b0);
        tick(1);

        // Command held valid while busy is taken on the first idle cycle
        pg_dly_i  = 16'd4;
        dom_dly_i = {16'd3, 16'd2};
        t = cyc;
        expect_done(1'b0, 1'b0, 1'b1, 2'b11, t + 13);
        issue(CmdHD);
        cmd_valid_i = 1'b1;
        cmd_i       = CmdHD;
        for (int i = 0; i < 40 && !found; i++) begin
            if (cmd_ready_o) begin
                found = 1'b1;
                acc   = cyc;
                expect_done(1'b1, 1'b0, 1'b1, 2'b11, acc + 1);
            end
            tick(1);
        end
        cmd_valid_i = 1'b0;
        check_eq("held_found", found, 1);
        check_eq("held_accept_cycle", acc, t + 13);
        tick(1);

        // core_rst mid-sequence: back to reset values, no done
        core_rst = 1'b1;
        tick(1);
        core_rst = 1'b0;
        check_out("crst_on", 1'b0, 2'b00, 1'b0);
        tick(1);
        t = cyc;
        issue(CmdHD);
        tick(7);
        check_out("crst_t8", 1'b1, 2'b00, 1'b0);
        tick(1);
        check_out("crst_t9", 1'b1, 2'b01, 1'b0);
        core_rst = 1'b1;
        tick(1);
        check_out("crst_mid", 1'b0, 2'b00, 1'b0);
        check_eq("crst_ready", cmd_ready_o, 1);
        check_eq("crst_busy", busy_o, 0);
        check_eq("crst_done", done_o, 0);
        core_rst = 1'b0;
        tick(4);

        check_eq("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
